ft245_sync_phy: RTL and testbench

Pin-level controller for the FT232H in synchronous 245 FIFO mode, clocked by the chip's 60 MHz CLKOUT. Sits between the command/stream controller (byte-level read/write handshake) and the FT232H pads. It arbitrates the shared bidirectional data bus between host-to-FPGA reads and FPGA-to-host writes, and sequences OE#/RD#/WR# with bus turnaround. A small transmit skid buffer absorbs the one-cycle lag between the `wr_ready` sample and the `write` assertion.

---
 rtl/ft245_sync_phy_pkg.sv | 25 ++
 rtl/ft245_sync_phy_if.sv | 41 ++++
 rtl/ft245_sync_phy_tx_skid.sv | 61 ++++++
 rtl/ft245_sync_phy.sv | 120 ++++++++++++
 tb/tb_ft245_sync_phy.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft245_sync_phy_pkg.sv
// rtl/ft245_sync_phy_pkg.sv - shared types and constants for the FT232H sync 245 FIFO PHY
//
// Package ft245_pkg:
//   CLK_HZ      FT232H CLKOUT frequency
//   BUS_W       ADBUS width
//   ft_state_e  one-hot PHY sequencer states
//   is_rd_state true while the PHY owns a read transaction on the bus
package ft245_pkg;

  localparam int CLK_HZ = 60_000_000;
  localparam int BUS_W  = 8;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_WR      = 5'b00010,
    ST_RD_OE   = 5'b00100,
    ST_RD_DATA = 5'b01000,
    ST_RD_END  = 5'b10000
  } ft_state_e;

  function automatic logic is_rd_state(input ft_state_e s);
    return (s == ST_RD_OE) || (s == ST_RD_DATA) || (s == ST_RD_END);
  endfunction

endpackage

// File: rtl/ft245_sync_phy_if.sv
// rtl/ft245_sync_phy_if.sv - byte handshake and FT232H pad bundle for ft245_sync_phy
//
// User side : write, write_data, wr_ready, read, rd_ready, data_valid, read_data, tx_overflow
// Pad side  : rxf_n, txe_n, data_i, data_o, data_oe, oe_n, rd_n, wr_n, siwu_n
// Modports  : slave  = the PHY
//             master = the stream controller together with the pad/IOBUF level
interface ft245_sync_phy_if;
  import ft245_pkg::*;

  logic             write;
  logic [BUS_W-1:0] write_data;
  logic             wr_ready;
  logic             read;
  logic             rd_ready;
  logic             data_valid;
  logic [BUS_W-1:0] read_data;
  logic             tx_overflow;

  logic             rxf_n;
  logic             txe_n;
  logic [BUS_W-1:0] data_i;
  logic [BUS_W-1:0] data_o;
  logic             data_oe;
  logic             oe_n;
  logic             rd_n;
  logic             wr_n;
  logic             siwu_n;

  modport slave (
    input  write, write_data, read, rxf_n, txe_n, data_i,
    output wr_ready, rd_ready, data_valid, read_data, tx_overflow,
           data_o, data_oe, oe_n, rd_n, wr_n, siwu_n
  );

  modport master (
    output write, write_data, read, rxf_n, txe_n, data_i,
    input  wr_ready, rd_ready, data_valid, read_data, tx_overflow,
           data_o, data_oe, oe_n, rd_n, wr_n, siwu_n
  );

endinterface

// File: rtl/ft245_sync_phy_tx_skid.sv
// rtl/ft245_sync_phy_tx_skid.sv - transmit skid FIFO for ft245_sync_phy
//
// Module ft_tx_skid (DEPTH entries of WIDTH bits, DEPTH a power of two)
//   clk, rst_n  clock, asynchronous active-low reset (flushes pointers/count)
//   push, din   write din when not full
//   pop         drop the head entry when not empty
//   dout        head entry, combinational
//   count       occupancy, 0..DEPTH
//   full, empty occupancy flags
module ft_tx_skid #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full buffer is refused even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ft245_sync_phy.sv
// rtl/ft245_sync_phy.sv - FT232H synchronous 245 FIFO pin-level controller
//
// Module ft245_sync_phy
//   TXBUF_DEPTH  transmit skid buffer entries (power of two, >= 4)
//   clk          FT232H CLKOUT (60 MHz)
//   rst_n        asynchronous active-low reset
//   bus          ft245_sync_phy_if.slave: user byte handshake plus FT232H pads
// The PHY arbitrates the shared ADBUS between host reads (priority) and
// FPGA writes, sequencing OE#/RD#/WR# with a dead cycle on every turnaround.
module ft245_sync_phy
  import ft245_pkg::*;
#(
  parameter int TXBUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ft245_sync_phy_if.slave     bus
);

  localparam int CW = $clog2(TXBUF_DEPTH) + 1;

  logic [CW-1:0]    tx_count;
  logic             tx_full;
  logic             tx_empty;
  logic [BUS_W-1:0] tx_head;
  logic             tx_push;
  logic             wr_strobe;

  ft_state_e        state;
  ft_state_e        state_nxt;
  logic             rd_pend;
  logic             rd_pend_nxt;
  logic             rd_req;
  logic             capture;

  logic             data_oe_q;
  logic             oe_n_q;
  logic             rd_ready_q;
  logic             data_valid_q;
  logic             tx_overflow_q;
  logic [BUS_W-1:0] read_data_q;

  assign tx_push = bus.write & ~tx_full;

  ft_tx_skid #(
    .DEPTH (TXBUF_DEPTH),
    .WIDTH (BUS_W)
  ) u_tx_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (wr_strobe),
    .din   (bus.write_data),
    .dout  (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // WR# follows TXE# combinationally so a byte is never strobed into a full chip.
  assign wr_strobe = (state == ST_WR) & ~tx_empty & ~bus.txe_n;
  // RD# follows RXF# so a stalled host leaves the request pending.
  assign capture   = (state == ST_RD_DATA) & ~bus.rxf_n;
  assign rd_req    = bus.read & rd_ready_q;
  assign rd_pend_nxt = rd_req | (rd_pend & ~capture);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (rd_pend && !bus.rxf_n)        state_nxt = ST_RD_OE;
        else if (!tx_empty && !bus.txe_n) state_nxt = ST_WR;
      end
      // The byte strobed in the exit cycle is still accepted by the chip.
      ST_WR:      if (tx_empty || bus.txe_n || rd_pend) state_nxt = ST_IDLE;
      ST_RD_OE:   state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (!bus.rxf_n) state_nxt = ST_RD_END;
      ST_RD_END:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rd_pend       <= 1'b0;
      data_oe_q     <= 1'b0;
      oe_n_q        <= 1'b1;
      rd_ready_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      read_data_q   <= '0;
    end else begin
      state        <= state_nxt;
      rd_pend      <= rd_pend_nxt;
      // Bus direction is decoded from the next state so it is a clean flop
      // output; IDLE between WR and RD_OE provides the turnaround gap.
      data_oe_q    <= (state_nxt == ST_WR);
      oe_n_q       <= ~((state_nxt == ST_RD_OE) || (state_nxt == ST_RD_DATA));
      // Uses next-cycle values so a request cannot be accepted twice.
      rd_ready_q   <= ~bus.rxf_n & ~rd_pend_nxt & ~is_rd_state(state_nxt);
      data_valid_q <= capture;
      if (capture)             read_data_q   <= bus.data_i;
      if (bus.write & tx_full) tx_overflow_q <= 1'b1;
    end
  end

  assign bus.wr_ready    = (tx_count <= CW'(TXBUF_DEPTH - 2));
  assign bus.rd_ready    = rd_ready_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.read_data   = read_data_q;
  assign bus.tx_overflow = tx_overflow_q;
  assign bus.data_oe     = data_oe_q;
  assign bus.data_o      = data_oe_q ? tx_head : '0;
  assign bus.oe_n        = oe_n_q;
  assign bus.rd_n        = ~capture;
  assign bus.wr_n        = ~wr_strobe;
  assign bus.siwu_n      = 1'b1;

endmodule

// File: tb/tb_ft245_sync_phy.sv
// tb/tb_ft245_sync_phy.sv - self-checking bench for ft245_sync_phy
module tb_ft245_sync_phy;
  import ft245_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft245_sync_phy_if bus ();

  ft245_sync_phy #(.TXBUF_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int viol = 0;
  int dv_cnt = 0;
  logic [7:0] tx_seen[$];
  logic [7:0] rx_seen[$];

  typedef struct {
    logic rd; logic rxf_n; logic [7:0] di; logic wr; logic [7:0] wd; logic txe_n;
    logic oe_n; logic rd_n; logic doe; logic dv; logic rdy; logic wr_n; logic wrdy;
    logic [7:0] rdata; logic cdo; logic [7:0] dout;
  } vec_t;

  // Bytes accepted by the chip on WR#/read strobes, plus bus rules that must hold every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.wr_n) tx_seen.push_back(bus.data_o);
      if (bus.data_valid) begin
        rx_seen.push_back(bus.read_data);
        dv_cnt++;
      end
      if (bus.data_oe && !bus.oe_n) viol++;
      if (!bus.wr_n && bus.txe_n) viol++;
      if (!bus.rd_n && (bus.oe_n || bus.rxf_n)) viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_seq(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      cyc();
      bus.write = 1'b1;
      bus.write_data = first + 8'(i);
    end
    cyc();
    bus.write = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 40 && tx_seen.size() < n; k++) cyc();
    chk("tx_drain_timeout", tx_seen.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[16];
    logic [7:0] host_q[$];
    logic [7:0] host_all[$];
    logic [7:0] tx_exp[$];
    int consumed;
    int found;
    int dvb;
    int n;

    tbl[0]  = '{0,0,8'h11,0,8'h00,1, 1,1,0,0,0,1,1,8'h00,1,8'h00};
    tbl[1]  = '{1,0,8'h11,0,8'h00,1, 1,1,0,0,1,1,1,8'h00,1,8'h00};
    tbl[2]  = '{0,0,8'h11,0,8'h00,1, 1,1,0,0,0,1,1,8'h00,1,8'h00};
    tbl[3]  = '{0,0,8'h11,0,8'h00,1, 0,1,0,0,0,1,1,8'h00,1,8'h00};
    tbl[4]  = '{0,0,8'h11,0,8'h00,1, 0,0,0,0,0,1,1,8'h00,1,8'h00};
    tbl[5]  = '{0,0,8'h11,0,8'h00,1, 1,1,0,1,0,1,1,8'h11,1,8'h00};
    tbl[6]  = '{0,1,8'h00,0,8'h00,1, 1,1,0,0,1,1,1,8'h11,1,8'h00};
    tbl[7]  = '{0,1,8'h00,0,8'h00,1, 1,1,0,0,0,1,1,8'h11,1,8'h00};
    tbl[8]  = '{0,1,8'h00,1,8'h01,0, 1,1,0,0,0,1,1,8'h11,1,8'h00};
    tbl[9]  = '{0,1,8'h00,1,8'h02,0, 1,1,0,0,0,1,1,8'h11,1,8'h00};
    tbl[10] = '{0,1,8'h00,1,8'h03,0, 1,1,1,0,0,0,1,8'h11,1,8'h01};
    tbl[11] = '{0,1,8'h00,1,8'h04,0, 1,1,1,0,0,0,1,8'h11,1,8'h02};
    tbl[12] = '{0,1,8'h00,0,8'h00,0, 1,1,1,0,0,0,1,8'h11,1,8'h03};
    tbl[13] = '{0,1,8'h00,0,8'h00,0, 1,1,1,0,0,0,1,8'h11,1,8'h04};
    tbl[14] = '{0,1,8'h00,0,8'h00,0, 1,1,1,0,0,1,1,8'h11,0,8'h00};
    tbl[15] = '{0,1,8'h00,0,8'h00,0, 1,1,0,0,0,1,1,8'h11,1,8'h00};

    bus.write = 1'b0; bus.write_data = 8'h00; bus.read = 1'b0;
    bus.rxf_n = 1'b1; bus.txe_n = 1'b1; bus.data_i = 8'h00;

    // Reset values
    repeat (2) cyc();
    smp();
    chk("rst_oe_n", bus.oe_n, 1);
    chk("rst_rd_n", bus.rd_n, 1);
    chk("rst_wr_n", bus.wr_n, 1);
    chk("rst_siwu_n", bus.siwu_n, 1);
    chk("rst_data_oe", bus.data_oe, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_tx_overflow", bus.tx_overflow, 0);
    chk("rst_read_data", bus.read_data, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Single read of 8'h11 then a four-byte write burst, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc();
      bus.read = tbl[i].rd; bus.rxf_n = tbl[i].rxf_n; bus.data_i = tbl[i].di;
      bus.write = tbl[i].wr; bus.write_data = tbl[i].wd; bus.txe_n = tbl[i].txe_n;
      smp();
      chk($sformatf("vec%0d_oe_n", i), bus.oe_n, tbl[i].oe_n);
      chk($sformatf("vec%0d_rd_n", i), bus.rd_n, tbl[i].rd_n);
      chk($sformatf("vec%0d_data_oe", i), bus.data_oe, tbl[i].doe);
      chk($sformatf("vec%0d_data_valid", i), bus.data_valid, tbl[i].dv);
      chk($sformatf("vec%0d_rd_ready", i), bus.rd_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_wr_n", i), bus.wr_n, tbl[i].wr_n);
      chk($sformatf("vec%0d_wr_ready", i), bus.wr_ready, tbl[i].wrdy);
      chk($sformatf("vec%0d_read_data", i), bus.read_data, tbl[i].rdata);
      chk($sformatf("vec%0d_tx_overflow", i), bus.tx_overflow, 0);
      if (tbl[i].cdo) chk($sformatf("vec%0d_data_o", i), bus.data_o, tbl[i].dout);
    end

    // Overflow with TXE# high, then TXE# stall mid-burst
    cyc();
    bus.txe_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      bus.write = 1'b1;
      bus.write_data = 8'(i + 1);
      smp();
      chk($sformatf("ovf_wr_ready%0d", i), bus.wr_ready, (i <= 2) ? 1 : 0);
    end
    cyc();
    bus.write = 1'b0;
    smp();
    chk("ovf_sticky", bus.tx_overflow, 1);
    chk("ovf_full_wr_ready", bus.wr_ready, 0);
    tx_seen.delete();
    cyc();
    bus.txe_n = 1'b0;
    smp();
    chk("stall_idle_wr_n", bus.wr_n, 1);
    cyc(); smp();
    chk("stall_b0_wr_n", bus.wr_n, 0);
    chk("stall_b0_data", bus.data_o, 8'h01);
    cyc(); smp();
    chk("stall_b1_data", bus.data_o, 8'h02);
    cyc();
    bus.txe_n = 1'b1;
    smp();
    chk("stall_wr_n_same_cycle", bus.wr_n, 1);
    repeat (3) cyc();
    chk("stall_held_count", tx_seen.size(), 2);
    bus.txe_n = 1'b0;
    wait_tx(4);
    repeat (5) cyc();
    chk("stall_no_extra", tx_seen.size(), 4);
    for (int j = 0; j < 4 && j < tx_seen.size(); j++)
      chk($sformatf("stall_order%0d", j), tx_seen[j], j + 1);
    chk("ovf_still_set", bus.tx_overflow, 1);
    rst_n = 1'b0;
    #1;
    chk("ovf_cleared_by_reset", bus.tx_overflow, 0);
    cyc();
    rst_n = 1'b1;

    // Read preempts a write burst
    bus.txe_n = 1'b1; bus.rxf_n = 1'b0; bus.data_i = 8'h0F;
    push_seq(4, 8'h01);
    tx_seen.delete();
    bus.txe_n = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (!bus.wr_n) begin found = 1; break; end
      cyc();
    end
    chk("preempt_burst_started", found, 1);
    cyc();
    bus.read = 1'b1;
    smp();
    chk("preempt_rd_ready", bus.rd_ready, 1);
    cyc();
    bus.read = 1'b0;
    found = 0;
    for (int k = 0; k < 12; k++) begin
      smp();
      if (bus.data_valid) begin found = 1; break; end
      cyc();
    end
    chk("preempt_dv_seen", found, 1);
    chk("preempt_read_data", bus.read_data, 8'h0F);
    chk("preempt_bytes_before_read", tx_seen.size(), 3);
    cyc();
    bus.rxf_n = 1'b1;
    wait_tx(4);
    for (int j = 0; j < 4 && j < tx_seen.size(); j++)
      chk($sformatf("preempt_order%0d", j), tx_seen[j], j + 1);

    // Asynchronous reset while waiting in RD_DATA
    cyc(); bus.rxf_n = 1'b0; bus.data_i = 8'h22;
    cyc();
    cyc(); bus.read = 1'b1;
    cyc(); bus.read = 1'b0;
    cyc();
    cyc(); bus.rxf_n = 1'b1;
    smp();
    chk("rstrd_oe_low", bus.oe_n, 0);
    cyc(); bus.rxf_n = 1'b0;
    #1;
    chk("rstrd_rd_low", bus.rd_n, 0);
    dvb = dv_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstrd_oe_n", bus.oe_n, 1);
    chk("rstrd_rd_n", bus.rd_n, 1);
    chk("rstrd_data_oe", bus.data_oe, 0);
    cyc(); cyc();
    rst_n = 1'b1; bus.rxf_n = 1'b1;
    repeat (6) cyc();
    chk("rstrd_no_dv", dv_cnt, dvb);
    chk("rstrd_read_data", bus.read_data, 0);

    // Randomised traffic against a host-side queue model
    for (int i = 0; i < 200; i++) begin
      host_q.push_back(8'($urandom_range(0, 255)));
      host_all.push_back(host_q[i]);
    end
    tx_seen.delete(); rx_seen.delete();
    consumed = 0;
    for (n = 0; n < 1560; n++) begin
      cyc();
      if (n < 1500) begin
        bus.txe_n = ($urandom_range(0, 2) == 0);
        bus.rxf_n = (host_q.size() == 0) || ($urandom_range(0, 3) == 0);
        bus.read  = ($urandom_range(0, 2) == 0);
        if (bus.wr_ready && $urandom_range(0, 1) == 1) begin
          bus.write = 1'b1;
          bus.write_data = 8'($urandom_range(0, 255));
          tx_exp.push_back(bus.write_data);
        end else begin
          bus.write = 1'b0;
        end
      end else begin
        bus.txe_n = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.rxf_n = (host_q.size() == 0);
      end
      bus.data_i = (host_q.size() != 0) ? host_q[0] : 8'h00;
      smp();
      if (!bus.rd_n) begin
        void'(host_q.pop_front());
        consumed++;
      end
    end
    chk("rnd_tx_count", tx_seen.size(), tx_exp.size());
    for (int j = 0; j < tx_exp.size() && j < tx_seen.size(); j++)
      chk($sformatf("rnd_tx%0d", j), tx_seen[j], tx_exp[j]);
    chk("rnd_rx_count", rx_seen.size(), consumed);
    for (int j = 0; j < rx_seen.size() && j < host_all.size(); j++)
      chk($sformatf("rnd_rx%0d", j), rx_seen[j], host_all[j]);
    chk("rnd_no_overflow", bus.tx_overflow, 0);
    chk("bus_rules", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
